// File: rtl/dmem_arbiter_if.sv
// Core-side bus of the shared data-memory arbiter: per-core request
// fields packed side by side, plus the one-hot grant/read-valid returns
// and the broadcast read data.
interface dmem_arbiter_if #(
  parameter int CORE_COUNT = 4,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12
);
  logic [CORE_COUNT-1:0]            req;
  logic [CORE_COUNT-1:0]            wrEn;
  logic [CORE_COUNT*ADDR_WIDTH-1:0] addr;
  logic [CORE_COUNT*DATA_WIDTH-1:0] wrData;
  logic [CORE_COUNT-1:0]            grant;
  logic [CORE_COUNT-1:0]            rdValid;
  logic [DATA_WIDTH-1:0]            rdData;

  // Cores drive requests and observe the arbiter's answers
  modport master (
    output req, wrEn, addr, wrData,
    input  grant, rdValid, rdData
  );

  // The arbiter observes requests and drives the answers
  modport slave (
    input  req, wrEn, addr, wrData,
    output grant, rdValid, rdData
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous-read data RAM among
// CORE_COUNT cores. Grants and the RAM command are registered; read data
// comes back from the RAM one cycle after the grant and is flagged to the
// owning core with a one-hot rdValid.
module dmem_arbiter #(
  parameter int CORE_COUNT = 4,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rstN,
  dmem_arbiter_if.slave         core,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wrData,
  output logic                  mem_wrEn,
  input  logic [DATA_WIDTH-1:0] mem_rdData,
  output logic                  busy
);

  localparam int PTR_W = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(CORE_COUNT - 1);

  logic [PTR_W-1:0]      ptr;
  logic [PTR_W-1:0]      win_p0;
  logic                  found_p0;
  logic [CORE_COUNT-1:0] elig_p0;
  logic [PTR_W-1:0]      scan_idx;
  int                    scan_pos;

  logic [ADDR_WIDTH-1:0] addr_a   [CORE_COUNT];
  logic [DATA_WIDTH-1:0] wrdata_a [CORE_COUNT];

  genvar g;
  for (g = 0; g < CORE_COUNT; g++) begin : g_unpack
    assign addr_a[g]   = core.addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wrdata_a[g] = core.wrData[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // The core currently holding grant is masked so a still-high req is not
  // granted a second time for the same access.
  assign elig_p0 = core.req & ~core.grant;

  // Search ptr, ptr+1, ... with wrap for the first eligible core
  always_comb begin
    found_p0 = 1'b0;
    win_p0   = '0;
    scan_pos = 0;
    scan_idx = '0;
    for (int i = 0; i < CORE_COUNT; i++) begin
      scan_pos = int'(ptr) + i;
      if (scan_pos >= CORE_COUNT) scan_pos = scan_pos - CORE_COUNT;
      scan_idx = PTR_W'(scan_pos);
      if (!found_p0 && elig_p0[scan_idx]) begin
        found_p0 = 1'b1;
        win_p0   = scan_idx;
      end
    end
  end

  // ---- stage 1: registered grant, RAM command and read-return flag ----
  // Register the winner's command; a read granted last cycle returns now
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      core.grant   <= '0;
      core.rdValid <= '0;
      mem_wrEn     <= 1'b0;
      mem_addr     <= '0;
      mem_wrData   <= '0;
      ptr          <= '0;
    end else begin
      core.rdValid <= core.grant & {CORE_COUNT{~mem_wrEn}};
      if (found_p0) begin
        core.grant <= CORE_COUNT'(1) << win_p0;
        mem_addr   <= addr_a[win_p0];
        mem_wrData <= wrdata_a[win_p0];
        mem_wrEn   <= core.wrEn[win_p0];
        ptr        <= (win_p0 == LAST_IDX) ? '0 : win_p0 + PTR_W'(1);
      end else begin
        core.grant <= '0;
        mem_wrEn   <= 1'b0;
      end
    end
  end

  // RAM output is already aligned with rdValid, so it is simply broadcast
  assign core.rdData = mem_rdData;
  assign busy        = (|core.req) | (|core.grant) | (|core.rdValid);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed sequences and vector tables, then a
// randomized run of protocol-obeying cores, all checked against a
// cycle-level reference model of the arbitration rules and a shadow RAM.
module tb_dmem_arbiter;
  localparam int NC = 4;
  localparam int AW = 12;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rstN;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wrData;
  logic          mem_wrEn;
  logic [DW-1:0] mem_rdData;
  logic          busy;

  dmem_arbiter_if #(.CORE_COUNT(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  dmem_arbiter #(.CORE_COUNT(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rstN      (rstN),
    .core      (bus),
    .mem_addr  (mem_addr),
    .mem_wrData(mem_wrData),
    .mem_wrEn  (mem_wrEn),
    .mem_rdData(mem_rdData),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM, read-before-write
  logic [DW-1:0] ram [1 << AW];
  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] <= '0;
    ram[12'h010] <= 12'h5A3;
  end
  always @(posedge clk) begin
    if (mem_wrEn) ram[mem_addr] <= mem_wrData;
    mem_rdData <= ram[mem_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] mmem [1 << AW];
  int            m_grant;   // core holding grant after the edge, -1 none
  int            m_rdv;     // core receiving read data, -1 none
  int            m_ptr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic          m_wr;
  logic [DW-1:0] m_rdexp;
  int            waits [NC];

  task automatic model_reset();
    m_grant = -1; m_rdv = -1; m_ptr = 0;
    m_addr = '0; m_data = '0; m_wr = 1'b0;
    for (int j = 0; j < NC; j++) waits[j] = 0;
  endtask

  // Expected state after the coming edge, from the inputs now on the bus
  task automatic model_next();
    int w;
    int idx;
    w = -1;
    for (int k = 0; k < NC; k++) begin
      idx = (m_ptr + k) % NC;
      if (w < 0 && bus.req[idx] && idx != m_grant) w = idx;
    end
    if (m_grant >= 0 && !m_wr) begin
      m_rdv   = m_grant;
      m_rdexp = mmem[m_addr];
    end else begin
      m_rdv = -1;
    end
    if (w >= 0) begin
      n_tests++;
      if (waits[w] > NC - 1) begin
        n_fail++;
        $display("FAIL fairness: core %0d waited %0d grants, limit %0d", w, waits[w], NC - 1);
      end
      for (int j = 0; j < NC; j++) begin
        if (!bus.req[j]) waits[j] = 0;
        else if (j != w && j != m_grant) waits[j]++;
      end
      waits[w] = 0;
      m_grant = w;
      m_addr  = bus.addr[w*AW +: AW];
      m_data  = bus.wrData[w*DW +: DW];
      m_wr    = bus.wrEn[w];
      if (m_wr) mmem[m_addr] = m_data;
      m_ptr   = (w + 1) % NC;
    end else begin
      m_grant = -1;
      m_wr    = 1'b0;
    end
  endtask

  task automatic compare_model();
    logic [NC-1:0] eg, ev;
    eg = (m_grant >= 0) ? NC'(1) << m_grant : '0;
    ev = (m_rdv >= 0) ? NC'(1) << m_rdv : '0;
    chk("grant", 32'(bus.grant), 32'(eg));
    chk("rdValid", 32'(bus.rdValid), 32'(ev));
    chk("mem_wrEn", 32'(mem_wrEn), 32'(m_wr));
    chk("mem_addr", 32'(mem_addr), 32'(m_addr));
    chk("mem_wrData", 32'(mem_wrData), 32'(m_data));
    chk("busy", 32'(busy), 32'((|bus.req) | (|eg) | (|ev)));
    if (m_rdv >= 0) chk("rdData", 32'(bus.rdData), 32'(m_rdexp));
  endtask

  // One clock: model predicts, edge, outputs checked #1 later
  task automatic tick();
    if (!rstN) model_reset(); else model_next();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic set_core(input int i, input logic r, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req[i]              = r;
    bus.wrEn[i]             = w;
    bus.addr[i*AW +: AW]    = a;
    bus.wrData[i*DW +: DW]  = d;
  endtask

  typedef struct {
    logic [NC-1:0] req;
    logic [NC-1:0] wr;
    logic [NC-1:0] g;
    logic [NC-1:0] rv;
  } vec_t;

  vec_t held_tbl [5];
  vec_t cont_tbl [8];

  initial begin
    for (int i = 0; i < (1 << AW); i++) mmem[i] = '0;
    mmem[12'h010] = 12'h5A3;

    held_tbl[0] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000};
    held_tbl[1] = '{4'b0001, 4'b0000, 4'b0000, 4'b0001};
    held_tbl[2] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000};
    held_tbl[3] = '{4'b0001, 4'b0000, 4'b0000, 4'b0001};
    held_tbl[4] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000};

    cont_tbl[0] = '{4'b1111, 4'b0000, 4'b0001, 4'b0000};
    cont_tbl[1] = '{4'b1111, 4'b0000, 4'b0010, 4'b0001};
    cont_tbl[2] = '{4'b1111, 4'b0000, 4'b0100, 4'b0010};
    cont_tbl[3] = '{4'b1111, 4'b0000, 4'b1000, 4'b0100};
    cont_tbl[4] = '{4'b1111, 4'b0000, 4'b0001, 4'b1000};
    cont_tbl[5] = '{4'b1111, 4'b0000, 4'b0010, 4'b0001};
    cont_tbl[6] = '{4'b1111, 4'b0000, 4'b0100, 4'b0010};
    cont_tbl[7] = '{4'b1111, 4'b0000, 4'b1000, 4'b0100};

    bus.req = '0; bus.wrEn = '0; bus.addr = '0; bus.wrData = '0;
    rstN = 1'b0;
    model_reset();

    // Reset state
    tick();
    tick();
    chk("reset_grant", 32'(bus.grant), 32'h0);
    rstN = 1'b1;

    // Single read of core 2
    set_core(2, 1'b1, 1'b0, 12'h010, 12'h000);
    tick();
    chk("rd_grant", 32'(bus.grant), 32'h4);
    chk("rd_addr", 32'(mem_addr), 32'h010);
    set_core(2, 1'b0, 1'b0, 12'h010, 12'h000);
    tick();
    chk("rd_valid", 32'(bus.rdValid), 32'h4);
    chk("rd_data", 32'(bus.rdData), 32'h5A3);

    // Single write of core 1, then read back
    set_core(1, 1'b1, 1'b1, 12'h020, 12'h123);
    tick();
    chk("wr_grant", 32'(bus.grant), 32'h2);
    chk("wr_en", 32'(mem_wrEn), 32'h1);
    chk("wr_data", 32'(mem_wrData), 32'h123);
    set_core(1, 1'b0, 1'b0, 12'h020, 12'h000);
    tick();
    chk("wr_en_drop", 32'(mem_wrEn), 32'h0);
    chk("wr_no_rdv", 32'(bus.rdValid), 32'h0);
    set_core(1, 1'b1, 1'b0, 12'h020, 12'h000);
    tick();
    set_core(1, 1'b0, 1'b0, 12'h020, 12'h000);
    tick();
    chk("wr_readback", 32'(bus.rdData), 32'h123);

    // Wrap: steer ptr to 3, then cores 0 and 3 together
    set_core(2, 1'b1, 1'b0, 12'h030, 12'h000);
    tick();
    set_core(2, 1'b0, 1'b0, 12'h030, 12'h000);
    tick();
    set_core(0, 1'b1, 1'b0, 12'h031, 12'h000);
    set_core(3, 1'b1, 1'b0, 12'h032, 12'h000);
    tick();
    chk("wrap_first", 32'(bus.grant), 32'h8);
    set_core(3, 1'b0, 1'b0, 12'h032, 12'h000);
    tick();
    chk("wrap_second", 32'(bus.grant), 32'h1);
    set_core(0, 1'b0, 1'b0, 12'h031, 12'h000);
    tick();
    set_core(0, 1'b1, 1'b0, 12'h033, 12'h000);
    set_core(1, 1'b1, 1'b0, 12'h034, 12'h000);
    tick();
    chk("wrap_ptr1", 32'(bus.grant), 32'h2);
    set_core(1, 1'b0, 1'b0, 12'h034, 12'h000);
    tick();
    set_core(0, 1'b0, 1'b0, 12'h033, 12'h000);
    tick();
    tick();

    // Held req of core 0 alone: grant alternates
    set_core(0, 1'b0, 1'b0, 12'h040, 12'h000);
    chk("held_idle", 32'(bus.grant), 32'h0);
    for (int r = 0; r < 5; r++) begin
      bus.req  = held_tbl[r].req;
      bus.wrEn = held_tbl[r].wr;
      tick();
      chk($sformatf("held_g%0d", r), 32'(bus.grant), 32'(held_tbl[r].g));
      chk($sformatf("held_v%0d", r), 32'(bus.rdValid), 32'(held_tbl[r].rv));
    end
    bus.req = '0;
    tick();
    tick();

    // Reset in the grant cycle of a read
    set_core(0, 1'b1, 1'b0, 12'h050, 12'h000);
    tick();
    chk("mr_grant", 32'(bus.grant), 32'h1);
    rstN = 1'b0;
    #1;
    model_reset();
    chk("mr_grant0", 32'(bus.grant), 32'h0);
    chk("mr_rdv0", 32'(bus.rdValid), 32'h0);
    chk("mr_wren0", 32'(mem_wrEn), 32'h0);
    set_core(0, 1'b0, 1'b0, 12'h050, 12'h000);
    tick();
    tick();
    rstN = 1'b1;
    tick();
    chk("mr_no_rdv_a", 32'(bus.rdValid), 32'h0);
    tick();
    chk("mr_no_rdv_b", 32'(bus.rdValid), 32'h0);
    set_core(0, 1'b1, 1'b0, 12'h051, 12'h000);
    set_core(1, 1'b1, 1'b0, 12'h052, 12'h000);
    tick();
    chk("mr_first", 32'(bus.grant), 32'h1);
    set_core(0, 1'b0, 1'b0, 12'h051, 12'h000);
    tick();
    set_core(1, 1'b0, 1'b0, 12'h052, 12'h000);
    tick();
    tick();

    // Full contention from reset
    rstN = 1'b0;
    #1;
    for (int i = 0; i < NC; i++) set_core(i, 1'b1, 1'b0, AW'(12'h100 + i), 12'h000);
    tick();
    rstN = 1'b1;
    for (int r = 0; r < 8; r++) begin
      bus.req  = cont_tbl[r].req;
      bus.wrEn = cont_tbl[r].wr;
      tick();
      chk($sformatf("cont_g%0d", r), 32'(bus.grant), 32'(cont_tbl[r].g));
      chk($sformatf("cont_v%0d", r), 32'(bus.rdValid), 32'(cont_tbl[r].rv));
    end
    bus.req = '0;
    tick();
    tick();

    // Randomized cores obeying the handshake
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NC; i++) begin
        if (bus.grant[i]) begin
          if ($urandom_range(1) == 0) bus.req[i] = 1'b0;
          else set_core(i, 1'b1, 1'($urandom_range(1)), AW'($urandom_range(15)), DW'($urandom));
        end else if (!bus.req[i]) begin
          if ($urandom_range(2) == 0)
            set_core(i, 1'b1, 1'($urandom_range(1)), AW'($urandom_range(15)), DW'($urandom));
        end else if ($urandom_range(7) == 0) begin
          set_core(i, 1'b1, 1'($urandom_range(1)), AW'($urandom_range(15)), DW'($urandom));
        end
      end
      tick();
    end
    bus.req = '0;
    tick();
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
